// File: rtl/note_strobe_timer_if.sv
// note_strobe_timer_if: control inputs and note strobe/gate/tick outputs of the note timer.
interface note_strobe_timer_if #(
    parameter int TICK_BW = 16,
    parameter int DUR_BW  = 4
);
    logic               run_i;
    logic [TICK_BW-1:0] tempoDiv_i;
    logic [DUR_BW-1:0]  duration_i;
    logic               strb_o;
    logic               gate_o;
    logic               tick_o;

    modport master (output run_i, tempoDiv_i, duration_i, input strb_o, gate_o, tick_o);
    modport slave  (input run_i, tempoDiv_i, duration_i, output strb_o, gate_o, tick_o);
endinterface

// File: rtl/note_strobe_timer.sv
// note_strobe_timer: tempo prescaler and note-duration FSM producing gate, tick and note-advance strobe.
module note_strobe_timer #(
    parameter int TICK_BW   = 16,
    parameter int DUR_BW    = 4,
    parameter int GAP_TICKS = 1
) (
    input logic clk_i,
    input logic rst_i,
    note_strobe_timer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, STROBE} state_t;
    localparam logic [DUR_BW-1:0] GAP_LAST = DUR_BW'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);

    state_t             state, state_n;
    logic [TICK_BW-1:0] presc, presc_n;
    logic [DUR_BW-1:0]  tick_cnt, cnt_n, dur_lat, dur_n;
    logic               tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            dur_lat  <= '0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            tick_cnt <= cnt_n;
            dur_lat  <= dur_n;
        end
    end

    // counters default to cleared, so every exit to IDLE/LOAD/STROBE drops partial progress
    always_comb begin
        state_n = IDLE;
        presc_n = '0;
        cnt_n   = '0;
        dur_n   = dur_lat;
        tick    = (state == NOTE || state == GAP) && presc >= bus.tempoDiv_i;
        case (state)
            IDLE:   state_n = bus.run_i ? LOAD : IDLE;
            LOAD: begin
                state_n = bus.run_i ? NOTE : IDLE;
                dur_n   = bus.run_i ? bus.duration_i : dur_lat;
            end
            NOTE, GAP: if (bus.run_i) begin
                state_n = state;
                presc_n = tick ? '0 : presc + TICK_BW'(1);
                cnt_n   = tick ? tick_cnt + DUR_BW'(1) : tick_cnt;
                if (tick && state == NOTE && tick_cnt == dur_lat) begin
                    cnt_n   = '0;
                    state_n = (GAP_TICKS > 0) ? GAP : STROBE;
                end
                if (tick && state == GAP && tick_cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = STROBE;
                end
            end
            STROBE: state_n = bus.run_i ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.gate_o = (state == NOTE);
    assign bus.strb_o = (state == STROBE);
    assign bus.tick_o = tick;
endmodule

// File: tb/tb_note_strobe_timer.sv
// tb_note_strobe_timer: directed scenarios for the note timer, with and without an articulation gap.
module tb_note_strobe_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    note_strobe_timer_if #(.TICK_BW(16), .DUR_BW(4)) bus0 ();
    note_strobe_timer_if #(.TICK_BW(16), .DUR_BW(4)) bus1 ();

    note_strobe_timer #(.TICK_BW(16), .DUR_BW(4), .GAP_TICKS(1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    note_strobe_timer #(.TICK_BW(16), .DUR_BW(4), .GAP_TICKS(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Applies reset for two edges and releases it at a falling edge; sample k=0 follows the next rising edge.
    task automatic do_reset(input logic [15:0] t, input logic [3:0] d, input logic r0, input logic r1);
        @(negedge clk);
        rst = 1'b1;
        bus0.tempoDiv_i = t;
        bus0.duration_i = d;
        bus1.tempoDiv_i = t;
        bus1.duration_i = d;
        bus0.run_i = r0;
        bus1.run_i = r1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus0.run_i = 1'b1;
        bus1.run_i = 1'b1;
        bus0.tempoDiv_i = 16'd0;
        bus1.tempoDiv_i = 16'd0;
        bus0.duration_i = 4'd0;
        bus1.duration_i = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus0.gate_o !== 1'b0) begin errors++; $display("FAIL reset_gate0 got=%b exp=0", bus0.gate_o); end
        checks++; if (bus0.strb_o !== 1'b0) begin errors++; $display("FAIL reset_strb0 got=%b exp=0", bus0.strb_o); end
        checks++; if (bus0.tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick0 got=%b exp=0", bus0.tick_o); end
        checks++; if (bus1.gate_o !== 1'b0) begin errors++; $display("FAIL reset_gate1 got=%b exp=0", bus1.gate_o); end
        do_reset(16'd0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({bus0.gate_o, bus0.strb_o, bus0.tick_o} !== 3'b000) begin errors++; $display("FAIL idle_outs k=%0d got=%b exp=000", k, {bus0.gate_o, bus0.strb_o, bus0.tick_o}); end
        end
    endtask

    task automatic test_basic_gap();
        do_reset(16'd3, 4'd1, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            int p;
            @(negedge clk);
            p = k % 14;
            checks++; if (bus0.gate_o !== (p >= 1 && p <= 8)) begin errors++; $display("FAIL basic_gate k=%0d got=%b exp=%b", k, bus0.gate_o, (p >= 1 && p <= 8)); end
            checks++; if (bus0.strb_o !== (p == 13)) begin errors++; $display("FAIL basic_strb k=%0d got=%b exp=%b", k, bus0.strb_o, (p == 13)); end
            checks++; if (bus0.tick_o !== (p == 4 || p == 8 || p == 12)) begin errors++; $display("FAIL basic_tick k=%0d got=%b exp=%b", k, bus0.tick_o, (p == 4 || p == 8 || p == 12)); end
        end
        bus0.run_i = 1'b0;
    endtask

    task automatic test_no_gap_fast();
        do_reset(16'd0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++; if (bus1.gate_o !== (k % 3 == 1)) begin errors++; $display("FAIL fast_gate k=%0d got=%b exp=%b", k, bus1.gate_o, (k % 3 == 1)); end
            checks++; if (bus1.strb_o !== (k % 3 == 2)) begin errors++; $display("FAIL fast_strb k=%0d got=%b exp=%b", k, bus1.strb_o, (k % 3 == 2)); end
            checks++; if (bus1.tick_o !== (k % 3 == 1)) begin errors++; $display("FAIL fast_tick k=%0d got=%b exp=%b", k, bus1.tick_o, (k % 3 == 1)); end
        end
        bus1.run_i = 1'b0;
    endtask

    task automatic test_max_duration();
        do_reset(16'd1, 4'd15, 1'b1, 1'b0);
        for (int k = 0; k < 42; k++) begin
            logic eg, es;
            @(negedge clk);
            eg = (k >= 1 && k <= 32) || (k >= 37 && k <= 38);
            es = (k == 35) || (k == 41);
            checks++; if (bus0.gate_o !== eg) begin errors++; $display("FAIL maxdur_gate k=%0d got=%b exp=%b", k, bus0.gate_o, eg); end
            checks++; if (bus0.strb_o !== es) begin errors++; $display("FAIL maxdur_strb k=%0d got=%b exp=%b", k, bus0.strb_o, es); end
            if (k == 10) bus0.duration_i = 4'd0;
        end
        bus0.run_i = 1'b0;
    endtask

    task automatic test_run_drop();
        do_reset(16'd0, 4'd7, 1'b1, 1'b0);
        for (int k = 0; k < 22; k++) begin
            logic eg;
            @(negedge clk);
            eg = (k >= 1 && k <= 5) || (k >= 12 && k <= 19);
            checks++; if (bus0.gate_o !== eg) begin errors++; $display("FAIL drop_gate k=%0d got=%b exp=%b", k, bus0.gate_o, eg); end
            checks++; if (bus0.strb_o !== (k == 21)) begin errors++; $display("FAIL drop_strb k=%0d got=%b exp=%b", k, bus0.strb_o, (k == 21)); end
            if (k == 5) bus0.run_i = 1'b0;
            if (k == 10) bus0.run_i = 1'b1;
        end
        bus0.run_i = 1'b0;
    endtask

    task automatic test_tempo_change();
        do_reset(16'd10, 4'd15, 1'b1, 1'b0);
        for (int k = 0; k < 18; k++) begin
            logic et;
            @(negedge clk);
            et = (k >= 11) && ((k - 11) % 3 == 0);
            checks++; if (bus0.tick_o !== et) begin errors++; $display("FAIL tempo_tick k=%0d got=%b exp=%b", k, bus0.tick_o, et); end
            if (k == 8) begin
                bus0.tempoDiv_i = 16'd2;
                #1;
                checks++; if (bus0.tick_o !== 1'b1) begin errors++; $display("FAIL tempo_lowered_tick got=%b exp=1", bus0.tick_o); end
            end
        end
        bus0.run_i = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(16'd3, 4'd1, 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) @(negedge clk);
        checks++; if ({bus0.gate_o, bus0.tick_o} !== 2'b01) begin errors++; $display("FAIL gap_pre_reset got=%b exp=01", {bus0.gate_o, bus0.tick_o}); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus0.tick_o !== 1'b0) begin errors++; $display("FAIL async_tick got=%b exp=0", bus0.tick_o); end
        checks++; if (bus0.gate_o !== 1'b0) begin errors++; $display("FAIL async_gate got=%b exp=0", bus0.gate_o); end
        checks++; if (bus0.strb_o !== 1'b0) begin errors++; $display("FAIL async_strb got=%b exp=0", bus0.strb_o); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({bus0.gate_o, bus0.strb_o} !== 2'b00) begin errors++; $display("FAIL post_reset_load got=%b exp=00", {bus0.gate_o, bus0.strb_o}); end
        @(negedge clk);
        checks++; if (bus0.gate_o !== 1'b1) begin errors++; $display("FAIL post_reset_note got=%b exp=1", bus0.gate_o); end
        bus0.run_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_gap();
        test_no_gap_fast();
        test_max_duration();
        test_run_drop();
        test_tempo_change();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
